// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, issues one outstanding imem read at a time and drives the IF/ID register.
// Responses to requests made before a redirect are consumed and discarded.
module instruction_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  i_stall,
  input  logic                  i_redirect,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  output logic                  o_imem_req_valid,
  input  logic                  i_imem_req_ready,
  output logic [DATA_WIDTH-1:0] o_imem_req_addr,
  input  logic                  i_imem_rsp_valid,
  output logic                  o_imem_rsp_ready,
  input  logic [DATA_WIDTH-1:0] i_imem_rsp_data,
  input  logic                  i_imem_rsp_err,
  output logic [DATA_WIDTH-1:0] o_if_inst,
  output logic [DATA_WIDTH-1:0] o_if_pc,
  output logic                  o_if_valid,
  output logic                  o_if_fault
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] req_pc_q;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_err;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_err;
  logic                  load;

  // Instructions are word aligned, so the low two target bits are forced to zero.
  assign redirect_target  = i_redirect_pc & ~DATA_WIDTH'(3);
  assign o_imem_req_addr  = pc_q;
  assign o_imem_req_valid = clk_en & (state == S_REQ) & ~i_redirect;
  assign o_imem_rsp_ready = clk_en & ((state == S_WAIT) | (state == S_DROP));

  // Source for an IF/ID load: the live response, or the buffer captured during a stall.
  always_comb begin
    load      = 1'b0;
    load_data = i_imem_rsp_data;
    load_err  = i_imem_rsp_err;
    if (state == S_WAIT) begin
      load = i_imem_rsp_valid;
    end else if (state == S_HOLD) begin
      load      = 1'b1;
      load_data = hold_data;
      load_err  = hold_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      hold_data  <= '0;
      hold_err   <= 1'b0;
      o_if_inst  <= NOP_INST;
      o_if_pc    <= '0;
      o_if_valid <= 1'b0;
      o_if_fault <= 1'b0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (i_redirect) begin
            pc_q <= redirect_target;
          end else if (i_imem_req_ready) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + DATA_WIDTH'(4);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_redirect) begin
            pc_q  <= redirect_target;
            state <= i_imem_rsp_valid ? S_REQ : S_DROP;
          end else if (i_imem_rsp_valid && !i_stall) begin
            state <= S_REQ;
          end else if (i_imem_rsp_valid) begin
            hold_data <= i_imem_rsp_data;
            hold_err  <= i_imem_rsp_err;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_redirect) begin
            pc_q  <= redirect_target;
            state <= S_REQ;
          end else if (!i_stall) begin
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (i_redirect) begin
            pc_q <= redirect_target;
          end else if (i_imem_rsp_valid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (i_redirect) begin
        o_if_inst  <= NOP_INST;
        o_if_valid <= 1'b0;
        o_if_fault <= 1'b0;
      end else if (i_stall) begin
        o_if_inst  <= o_if_inst;
      end else if (load) begin
        o_if_inst  <= load_err ? NOP_INST : load_data;
        o_if_pc    <= req_pc_q;
        o_if_valid <= 1'b1;
        o_if_fault <= load_err;
      end else begin
        o_if_inst  <= NOP_INST;
        o_if_valid <= 1'b0;
        o_if_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected request addresses and IF/ID contents are
// queued as stimulus is driven and compared when the DUT issues or presents them.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  logic        req_valid, rsp_ready, if_valid, if_fault;
  logic [31:0] req_addr, if_inst, if_pc;
  logic        b_req_valid, b_rsp_ready, b_if_valid, b_if_fault;
  logic [31:0] b_req_addr, b_if_inst, b_if_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } if_exp_t;

  logic [31:0] exp_addr[$];
  if_exp_t     exp_if[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.DATA_WIDTH(32), .RESET_PC(32'h0), .NOP_INST(32'h13)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_stall(stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready),
    .o_imem_req_addr(req_addr), .i_imem_rsp_valid(rsp_valid), .o_imem_rsp_ready(rsp_ready),
    .i_imem_rsp_data(rsp_data), .i_imem_rsp_err(rsp_err), .o_if_inst(if_inst),
    .o_if_pc(if_pc), .o_if_valid(if_valid), .o_if_fault(if_fault)
  );

  // Second instance sharing all inputs; only its reset PC differs, to exercise PC wrap.
  instruction_fetch #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h13)) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_stall(stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_imem_req_valid(b_req_valid), .i_imem_req_ready(req_ready),
    .o_imem_req_addr(b_req_addr), .i_imem_rsp_valid(rsp_valid), .o_imem_rsp_ready(b_rsp_ready),
    .i_imem_rsp_data(rsp_data), .i_imem_rsp_err(rsp_err), .o_if_inst(b_if_inst),
    .o_if_pc(b_if_pc), .o_if_valid(b_if_valid), .o_if_fault(b_if_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then stop at the falling edge.
  task automatic drive(input logic en, input logic rq, input logic rv, input logic [31:0] d,
                       input logic e, input logic st, input logic rd, input logic [31:0] rp);
    @(posedge clk);
    #1;
    clk_en = en; req_ready = rq; rsp_valid = rv; rsp_data = d;
    rsp_err = e; stall = st; redirect = rd; redirect_pc = rp;
    @(negedge clk);
  endtask

  task automatic push_if(input logic [31:0] pc, input logic [31:0] inst, input logic fault);
    if_exp_t e;
    e.pc = pc; e.inst = inst; e.fault = fault;
    exp_if.push_back(e);
  endtask

  task automatic pop_if();
    if_exp_t e;
    e = exp_if.pop_front();
    chk1("if_valid", if_valid, 1'b1);
    chk("if_pc", if_pc, e.pc);
    chk("if_inst", if_inst, e.inst);
    chk1("if_fault", if_fault, e.fault);
  endtask

  // Every accepted request must match the next queued address.
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      if (exp_addr.size() == 0) chk1("req_unexpected", req_valid, 1'b0);
      else chk("req_addr", req_addr, exp_addr.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_inst", if_inst, 32'h13);
    chk("rst_if_pc", if_pc, 32'h0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_if_fault", if_fault, 1'b0);
    chk1("rst_req_valid", req_valid, 1'b0);
    chk1("rst_rsp_ready", rsp_ready, 1'b0);
    chk1("rst_b_req_valid", b_req_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("idle_req_valid", req_valid, 1'b0);

    // Back-to-back fetches with one-cycle response latency.
    exp_addr.push_back(32'h0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    chk("b_first_addr", b_req_addr, 32'hFFFF_FFFC);
    drive(1, 1, 1, 32'hA0, 0, 0, 0, 0);
    push_if(32'h0, 32'hA0, 1'b0);
    chk1("wait_req_valid", req_valid, 1'b0);
    chk1("wait_rsp_ready", rsp_ready, 1'b1);
    chk1("b_wait_rsp_ready", b_rsp_ready, 1'b1);
    exp_addr.push_back(32'h4);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    pop_if();
    chk("b_wrap_addr", b_req_addr, 32'h0);
    chk("b_if_pc", b_if_pc, 32'hFFFF_FFFC);
    chk("b_if_inst", b_if_inst, 32'hA0);
    chk1("b_if_valid", b_if_valid, 1'b1);
    chk1("b_if_fault", b_if_fault, 1'b0);
    drive(1, 1, 1, 32'hA1, 0, 0, 0, 0);
    push_if(32'h4, 32'hA1, 1'b0);
    chk1("bubble_valid", if_valid, 1'b0);
    exp_addr.push_back(32'h8);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    pop_if();
    drive(1, 1, 1, 32'hA2, 0, 0, 0, 0);
    push_if(32'h8, 32'hA2, 1'b0);

    // Decode stall spanning the response: IF/ID holds, no request while holding.
    exp_addr.push_back(32'hC);
    drive(1, 1, 0, 0, 0, 1, 0, 0);
    pop_if();
    drive(1, 1, 1, 32'hB0, 0, 1, 0, 0);
    chk("stall_hold_inst0", if_inst, 32'hA2);
    drive(1, 1, 0, 0, 0, 1, 0, 0);
    chk1("hold_req_valid", req_valid, 1'b0);
    chk1("hold_rsp_ready", rsp_ready, 1'b0);
    drive(1, 1, 0, 0, 0, 1, 0, 0);
    chk("stall_hold_inst1", if_inst, 32'hA2);
    chk1("stall_hold_valid", if_valid, 1'b1);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    push_if(32'hC, 32'hB0, 1'b0);
    chk1("unstall_req_valid", req_valid, 1'b0);
    exp_addr.push_back(32'h10);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    pop_if();

    // Redirect in S_WAIT; the stale response two cycles later is discarded.
    drive(1, 1, 0, 0, 0, 0, 1, 32'h100);
    chk1("redir_wait_rsp_ready", rsp_ready, 1'b1);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    chk1("drop_rsp_ready", rsp_ready, 1'b1);
    chk1("drop_req_valid", req_valid, 1'b0);
    drive(1, 1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    exp_addr.push_back(32'h100);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    chk1("stale_valid", if_valid, 1'b0);
    chk("stale_inst", if_inst, 32'h13);
    drive(1, 1, 1, 32'hC0, 0, 0, 0, 0);
    push_if(32'h100, 32'hC0, 1'b0);
    exp_addr.push_back(32'h104);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    pop_if();

    // Redirect coincident with the response, unaligned target.
    drive(1, 1, 1, 32'hBAD0_0BAD, 0, 0, 1, 32'h203);
    exp_addr.push_back(32'h200);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    chk1("coinc_valid", if_valid, 1'b0);
    chk("coinc_inst", if_inst, 32'h13);
    drive(1, 1, 1, 32'hD0, 0, 0, 0, 0);
    push_if(32'h200, 32'hD0, 1'b0);
    drive(1, 1, 0, 0, 0, 0, 1, 32'h40);
    chk1("redir_req_valid", req_valid, 1'b0);
    pop_if();

    // Access fault.
    exp_addr.push_back(32'h40);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    chk1("flush_valid", if_valid, 1'b0);
    drive(1, 1, 1, 32'h1234_5678, 1, 0, 0, 0);
    push_if(32'h40, 32'h13, 1'b1);
    exp_addr.push_back(32'h44);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    pop_if();

    // Clock enable low for four cycles in S_WAIT with a response pending.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 32'hEE, 0, 0, 0, 0);
      chk1("freeze_rsp_ready", rsp_ready, 1'b0);
      chk1("freeze_req_valid", req_valid, 1'b0);
      chk("freeze_if_pc", if_pc, 32'h40);
    end
    drive(1, 1, 1, 32'hE0, 0, 0, 0, 0);
    push_if(32'h44, 32'hE0, 1'b0);
    chk1("thaw_rsp_ready", rsp_ready, 1'b1);
    exp_addr.push_back(32'h48);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk1("bp_req_valid", req_valid, 1'b1);
    chk("bp_req_addr", req_addr, 32'h48);
    pop_if();
    drive(1, 1, 0, 0, 0, 0, 0, 0);

    // Reset while a request is outstanding.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rsp_valid = 1'b1;
    #1;
    chk1("midrst_rsp_ready", rsp_ready, 1'b0);
    chk1("midrst_req_valid", req_valid, 1'b0);
    chk("midrst_if_inst", if_inst, 32'h13);
    chk("midrst_if_pc", if_pc, 32'h0);
    chk("addr_q_left", 32'(exp_addr.size()), 32'h0);
    chk("if_q_left", 32'(exp_if.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
